dly_cmd_arbiter: RTL and testbench
==================================

DLY_CMD_ARBITER -- requirements
Module: dly_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_GB_SITES, default 20: number of GearBox delay sites.
REQ-002 SHALL have parameter NUM_DLY, default 5: user delay channels; legal range 1..NUM_GB_SITES.
REQ-003 SHALL have parameter DLY_LOC, width NUM_GB_SITES, default 'h0_0117: site map; its popcount SHALL equal NUM_DLY.
REQ-004 SHALL have parameter ADDR_WIDTH, default 5: GearBox address width.
REQ-005 SHALL have parameter DLY_TAP_WIDTH, default 6: tap value width.
REQ-006 SHALL have parameter RD_LAT, default 2, range 1..7: cycles from strobe to valid tap value.
REQ-007 Port clk, input, 1: rising-edge clock.
REQ-008 Port rst, input, 1: reset, synchronous, active-low.
REQ-009 Port usr_dly_ld, input, NUM_DLY: per-channel load request pulse.
REQ-010 Port usr_dly_adj, input, NUM_DLY: per-channel adjust request pulse.
REQ-011 Port usr_dly_incdec, input, NUM_DLY: direction, sampled with usr_dly_adj (1 = increment).
REQ-012 Port usr_rd_dly_value, input, NUM_DLY: per-channel read-only request pulse.
REQ-013 Port cntrl_dly_tap_value, input, DLY_TAP_WIDTH: tap value from GearBox.
REQ-014 Port f2g_dly_addr, output, ADDR_WIDTH: selected GearBox site.
REQ-015 Port cntrl_dly_ld, cntrl_dly_adj, cntrl_dly_incdec, output, 1 each: strobes to the selected site.
REQ-016 Port usr_dly_tap_value_out, output, NUM_DLY*DLY_TAP_WIDTH: per-channel captured tap values, channel k at slice k.
REQ-017 Port usr_dly_tap_vld, output, NUM_DLY: one-cycle pulse when channel k's tap register updates.
REQ-018 Port usr_dly_busy, output, NUM_DLY: channel has a pending or in-service command.
REQ-019 Port usr_dly_ovr, output, NUM_DLY: one-cycle pulse when a request is dropped.

Function
REQ-020 Channel k SHALL map to the site index of the k-th set bit of DLY_LOC, counting from bit 0, computed at elaboration (default: ch0..4 -> 0,1,2,4,8).
REQ-021 Per-channel pending register: op code (NONE/RD/ADJ/LD) plus stored incdec; a request sets it on the clock edge after the pulse.
REQ-022 Same-cycle requests on one channel: LD beats ADJ beats RD; losing requests are merged silently, with no ovr pulse.
REQ-023 Request on a channel already pending: LD overrides ADJ/RD; RD is absorbed; ADJ onto pending ADJ or LD is dropped with an ovr pulse.
REQ-024 Requests on the channel in service SHALL enter its pending register for a later grant.
REQ-025 FSM states: IDLE, SETUP, STROBE, WAIT, CAPTURE.
REQ-026 IDLE: if any channel pending, grant round-robin starting after the last granted channel, clear its pending entry, load f2g_dly_addr, go to SETUP.
REQ-027 SETUP: 1 cycle, address stable, no strobes -> STROBE.
REQ-028 STROBE: 1 cycle; assert cntrl_dly_ld (LD) or cntrl_dly_adj plus cntrl_dly_incdec (ADJ); no strobe for RD -> WAIT.
REQ-029 WAIT: exactly RD_LAT cycles via a counter -> CAPTURE.
REQ-030 CAPTURE: 1 cycle; register cntrl_dly_tap_value into the granted channel's slice; pulse usr_dly_tap_vld on the next cycle; -> IDLE.
REQ-031 Service time per command SHALL be RD_LAT+4 cycles from IDLE grant to return to IDLE; there are no back-to-back grants without IDLE.
REQ-032 f2g_dly_addr SHALL hold its last value outside SETUP..CAPTURE.
REQ-033 All strobes are registered, and at most one is high in any cycle except incdec, which only accompanies adj.
REQ-034 usr_dly_busy[k] = pending[k] OR (k granted AND state != IDLE).

Reset
REQ-035 While rst is low at a clock edge: state to IDLE, pending to NONE, round-robin pointer to channel 0, f2g_dly_addr to 0, strobes to 0, tap registers to 0, vld/busy/ovr to 0.
REQ-036 Reset asserted mid-command SHALL abort it with no capture or vld pulse, and strobes low from the next edge.

Structure
REQ-037 Op-code encoding, FSM state encoding and the RD_LAT counter width SHALL live in shared package dly_ctrl_pkg.
REQ-038 Round-robin grant SHALL be a sub-module dly_rr_arbiter (NUM_DLY requests, one-hot grant, pointer update on accept).

Verification
REQ-039 Use default params with RD_LAT=2. Pulse usr_dly_ld[3] -> f2g_dly_addr=0x04; cntrl_dly_ld high for 1 cycle one cycle later; cntrl_dly_tap_value=0x2A at CAPTURE -> slice 3 = 0x2A and usr_dly_tap_vld[3] pulses once, 7 cycles after the request.
REQ-040 Same-cycle pulses on usr_dly_adj[0] (incdec=1) and usr_dly_rd[4] -> ch0 served first (addr 0x00, adj+incdec strobe), then ch4 (addr 0x08, no strobe); two vld pulses, 6 cycles apart.
REQ-041 All 5 channels request LD continuously -> grants in order 0,1,2,3,4,0; no channel starves.
REQ-042 usr_dly_adj[2] twice while the first is pending -> usr_dly_ovr[2] pulses once; exactly one adj strobe issued.
REQ-043 Same-cycle LD+ADJ on ch1 -> only cntrl_dly_ld strobed; no ovr pulse.
REQ-044 rst low during WAIT -> no vld pulse; busy all 0 and all outputs at reset values on the next edge; a fresh request afterwards is served normally.

Source files
------------

// File: rtl/dly_ctrl_pkg.sv
// Shared encodings for the GearBox delay command arbiter: command op codes,
// sequencer states and the read-latency counter width.
package dly_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_ADJ  = 2'd2,
    OP_LD   = 2'd3
  } dly_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4
  } dly_state_e;

  // Holds RD_LAT-1 for RD_LAT up to 7.
  localparam int unsigned LAT_CNT_W = 3;

  // Index width that stays legal for a single channel.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dly_rr_arbiter.sv
// Round-robin grant over the channel pending flags. The pointer names the
// first channel to consider and moves past the winner only when the grant
// is accepted.
module dly_rr_arbiter
  import dly_ctrl_pkg::*;
#(
  parameter int N = 5,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          accept_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan requests from the pointer, wrapping once; first hit wins.
  always_comb begin
    int j;
    j         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!gnt_vld_o && req_i[j]) begin
        gnt_vld_o = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IW'(j);
      end
    end
  end

  // Next search starts just after the accepted winner.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && gnt_vld_o) begin
      ptr_d = (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  // Pointer register, synchronous active-low reset to channel 0.
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dly_cmd_arbiter.sv
// Serialises per-channel delay load/adjust/read requests onto the single
// GearBox delay control port and returns the resulting tap value.
//
// state   | meaning
// IDLE    | address held; grant next pending channel round-robin
// SETUP   | new address settles, no strobes
// STROBE  | one-cycle ld or adj(+incdec) strobe; nothing for a read
// WAIT    | RD_LAT cycles for the GearBox tap value to become valid
// CAPTURE | tap value latched into the granted channel's slice
module dly_cmd_arbiter
  import dly_ctrl_pkg::*;
#(
  parameter int                      NUM_GB_SITES  = 20,
  parameter int                      NUM_DLY       = 5,
  parameter logic [NUM_GB_SITES-1:0] DLY_LOC       = 'h0_0117,
  parameter int                      ADDR_WIDTH    = 5,
  parameter int                      DLY_TAP_WIDTH = 6,
  parameter int                      RD_LAT        = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_DLY-1:0]               usr_dly_ld,
  input  logic [NUM_DLY-1:0]               usr_dly_adj,
  input  logic [NUM_DLY-1:0]               usr_dly_incdec,
  input  logic [NUM_DLY-1:0]               usr_rd_dly_value,
  input  logic [DLY_TAP_WIDTH-1:0]         cntrl_dly_tap_value,
  output logic [ADDR_WIDTH-1:0]            f2g_dly_addr,
  output logic                             cntrl_dly_ld,
  output logic                             cntrl_dly_adj,
  output logic                             cntrl_dly_incdec,
  output logic [NUM_DLY*DLY_TAP_WIDTH-1:0] usr_dly_tap_value_out,
  output logic [NUM_DLY-1:0]               usr_dly_tap_vld,
  output logic [NUM_DLY-1:0]               usr_dly_busy,
  output logic [NUM_DLY-1:0]               usr_dly_ovr
);

  localparam int IW = idx_width(NUM_DLY);

  // Site index of the k-th set bit of DLY_LOC, counted from bit 0.
  function automatic int site_of(input int k);
    int seen;
    site_of = 0;
    seen    = 0;
    for (int b = 0; b < NUM_GB_SITES; b++) begin
      if (DLY_LOC[b]) begin
        if (seen == k) site_of = b;
        seen++;
      end
    end
  endfunction

  dly_state_e                 state_q, state_d;
  dly_op_e                    pend_op_q [NUM_DLY];
  dly_op_e                    pend_op_d [NUM_DLY];
  logic [NUM_DLY-1:0]         pend_inc_q, pend_inc_d;
  logic [NUM_DLY-1:0]         pend_vld;
  logic [NUM_DLY-1:0]         ovr_d, ovr_q;
  logic [NUM_DLY-1:0]         gnt_q, vld_q;
  logic [IW-1:0]              idx_q;
  dly_op_e                    op_q;
  logic                       inc_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [LAT_CNT_W-1:0]       cnt_q;
  logic                       ld_q, adj_q, incdec_q;
  logic [DLY_TAP_WIDTH-1:0]   tap_q [NUM_DLY];
  logic [ADDR_WIDTH-1:0]      site_tbl [NUM_DLY];
  logic [NUM_DLY-1:0]         rr_gnt;
  logic [IW-1:0]              rr_idx;
  logic                       rr_vld;
  logic                       accept;

  for (genvar g = 0; g < NUM_DLY; g++) begin : g_chan
    localparam int SITE = site_of(g);
    assign site_tbl[g] = ADDR_WIDTH'(SITE);
    assign pend_vld[g] = (pend_op_q[g] != OP_NONE);
    assign usr_dly_tap_value_out[g*DLY_TAP_WIDTH +: DLY_TAP_WIDTH] = tap_q[g];
  end

  assign accept = (state_q == ST_IDLE) && rr_vld;

  dly_rr_arbiter #(.N(NUM_DLY)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (pend_vld),
    .accept_i  (accept),
    .gnt_o     (rr_gnt),
    .gnt_idx_o (rr_idx),
    .gnt_vld_o (rr_vld)
  );

  // Pending update: a grant empties the entry first, so a request arriving
  // on the channel being granted queues behind it. LD always wins, RD only
  // fills an empty entry, ADJ onto ADJ/LD is dropped and flagged.
  always_comb begin
    pend_inc_d = pend_inc_q;
    ovr_d      = '0;
    for (int k = 0; k < NUM_DLY; k++) begin
      pend_op_d[k] = pend_op_q[k];
      if (accept && rr_gnt[k]) pend_op_d[k] = OP_NONE;
      if (usr_dly_ld[k]) begin
        pend_op_d[k] = OP_LD;
      end else if (usr_dly_adj[k]) begin
        if (pend_op_d[k] == OP_ADJ || pend_op_d[k] == OP_LD) begin
          ovr_d[k] = 1'b1;
        end else begin
          pend_op_d[k]  = OP_ADJ;
          pend_inc_d[k] = usr_dly_incdec[k];
        end
      end else if (usr_rd_dly_value[k] && pend_op_d[k] == OP_NONE) begin
        pend_op_d[k] = OP_RD;
      end
    end
  end

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_SETUP;
      ST_SETUP:   state_d = ST_STROBE;
      ST_STROBE:  state_d = ST_WAIT;
      ST_WAIT:    if (cnt_q == '0) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, pending, grant context, registered strobes, wait counter and taps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pend_inc_q <= '0;
      ovr_q      <= '0;
      gnt_q      <= '0;
      vld_q      <= '0;
      idx_q      <= '0;
      op_q       <= OP_NONE;
      inc_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      ld_q       <= 1'b0;
      adj_q      <= 1'b0;
      incdec_q   <= 1'b0;
      for (int k = 0; k < NUM_DLY; k++) begin
        pend_op_q[k] <= OP_NONE;
        tap_q[k]     <= '0;
      end
    end else begin
      state_q    <= state_d;
      pend_op_q  <= pend_op_d;
      pend_inc_q <= pend_inc_d;
      ovr_q      <= ovr_d;
      if (accept) begin
        gnt_q  <= rr_gnt;
        idx_q  <= rr_idx;
        op_q   <= pend_op_q[rr_idx];
        inc_q  <= pend_inc_q[rr_idx];
        addr_q <= site_tbl[rr_idx];
      end
      ld_q     <= (state_q == ST_SETUP) && (op_q == OP_LD);
      adj_q    <= (state_q == ST_SETUP) && (op_q == OP_ADJ);
      incdec_q <= (state_q == ST_SETUP) && (op_q == OP_ADJ) && inc_q;
      if (state_q == ST_STROBE)                cnt_q <= LAT_CNT_W'(RD_LAT - 1);
      else if (state_q == ST_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      vld_q <= '0;
      if (state_q == ST_CAPTURE) begin
        tap_q[idx_q] <= cntrl_dly_tap_value;
        vld_q        <= gnt_q;
      end
    end
  end

  assign f2g_dly_addr     = addr_q;
  assign cntrl_dly_ld     = ld_q;
  assign cntrl_dly_adj    = adj_q;
  assign cntrl_dly_incdec = incdec_q;
  assign usr_dly_tap_vld  = vld_q;
  assign usr_dly_ovr      = ovr_q;
  assign usr_dly_busy     = pend_vld | (gnt_q & {NUM_DLY{state_q != ST_IDLE}});

endmodule

// File: tb/tb_dly_cmd_arbiter.sv
// Bench for dly_cmd_arbiter: a request-level reference model predicts each
// served command (channel, op, site, completion cycle), drop pulses and busy
// flags; a monitor compares them against what the DUT presents.
module tb_dly_cmd_arbiter;

  localparam int ND     = 5;
  localparam int TW     = 6;
  localparam int AW     = 5;
  localparam int RD_LAT = 2;

  typedef struct {
    int ch;
    int op;    // 0 none, 1 read, 2 adjust, 3 load
    int inc;
    int addr;
    int vcyc;
  } exp_t;

  typedef struct {
    int cyc;
    int mask;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ND-1:0]     usr_dly_ld, usr_dly_adj, usr_dly_incdec, usr_rd_dly_value;
  logic [TW-1:0]     cntrl_dly_tap_value;
  logic [AW-1:0]     f2g_dly_addr;
  logic              cntrl_dly_ld, cntrl_dly_adj, cntrl_dly_incdec;
  logic [ND*TW-1:0]  usr_dly_tap_value_out;
  logic [ND-1:0]     usr_dly_tap_vld, usr_dly_busy, usr_dly_ovr;

  dly_cmd_arbiter #(
    .NUM_GB_SITES(20), .NUM_DLY(ND), .DLY_LOC(20'h0_0117),
    .ADDR_WIDTH(AW), .DLY_TAP_WIDTH(TW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .usr_dly_ld(usr_dly_ld), .usr_dly_adj(usr_dly_adj),
    .usr_dly_incdec(usr_dly_incdec), .usr_rd_dly_value(usr_rd_dly_value),
    .cntrl_dly_tap_value(cntrl_dly_tap_value),
    .f2g_dly_addr(f2g_dly_addr),
    .cntrl_dly_ld(cntrl_dly_ld), .cntrl_dly_adj(cntrl_dly_adj),
    .cntrl_dly_incdec(cntrl_dly_incdec),
    .usr_dly_tap_value_out(usr_dly_tap_value_out),
    .usr_dly_tap_vld(usr_dly_tap_vld), .usr_dly_busy(usr_dly_busy),
    .usr_dly_ovr(usr_dly_ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference model state.
  int   site_m [ND] = '{0, 1, 2, 4, 8};
  int   pend_m [ND];
  int   inc_m  [ND];
  int   ptr_m   = 0;
  int   free_at = 0;
  int   svc_m   = 0;
  int   tap_hist [8192];
  int   force_tap = -1;
  exp_t exp_q [$];
  ev_t  ovr_q [$];
  ev_t  busy_q [$];
  bit   mon_en = 1'b0;

  task automatic push_busy(input int c);
    ev_t b;
    b.cyc  = c + 1;
    b.mask = 0;
    for (int k = 0; k < ND; k++) if (pend_m[k] != 0) b.mask |= (1 << k);
    if (c + 1 < free_at) b.mask |= (1 << svc_m);
    busy_q.push_back(b);
  endtask

  // One cycle of the request-level model: serve if the port is free, then
  // merge this cycle's requests into the per-channel pending ops.
  task automatic model_cycle(input int c, input logic [ND-1:0] ld, adj, inc, rd);
    exp_t e;
    ev_t  o;
    bit   found;
    int   j;
    found = 0;
    if (c >= free_at) begin
      for (int i = 0; i < ND; i++) begin
        j = (ptr_m + i) % ND;
        if (!found && pend_m[j] != 0) begin
          found  = 1;
          e.ch   = j;
          e.op   = pend_m[j];
          e.inc  = inc_m[j];
          e.addr = site_m[j];
          e.vcyc = c + RD_LAT + 4;
          exp_q.push_back(e);
          pend_m[j] = 0;
          ptr_m     = (j + 1) % ND;
          free_at   = c + RD_LAT + 4;
          svc_m     = j;
        end
      end
    end
    o.cyc  = c + 1;
    o.mask = 0;
    for (int k = 0; k < ND; k++) begin
      if (ld[k]) pend_m[k] = 3;
      else if (adj[k]) begin
        if (pend_m[k] >= 2) o.mask |= (1 << k);
        else begin
          pend_m[k] = 2;
          inc_m[k]  = int'(inc[k]);
        end
      end else if (rd[k] && pend_m[k] == 0) pend_m[k] = 1;
    end
    if (o.mask != 0) ovr_q.push_back(o);
    push_busy(c);
  endtask

  // Reset sampled at the end of cycle c: anything due later is aborted.
  task automatic model_reset(input int c);
    exp_t ne [$];
    ev_t  no [$];
    ev_t  nb [$];
    for (int k = 0; k < ND; k++) begin
      pend_m[k] = 0;
      inc_m[k]  = 0;
    end
    ptr_m   = 0;
    free_at = 0;
    foreach (exp_q[i])  if (exp_q[i].vcyc <= c) ne.push_back(exp_q[i]);
    foreach (ovr_q[i])  if (ovr_q[i].cyc <= c)  no.push_back(ovr_q[i]);
    foreach (busy_q[i]) if (busy_q[i].cyc <= c) nb.push_back(busy_q[i]);
    exp_q  = ne;
    ovr_q  = no;
    busy_q = nb;
    push_busy(c);
  endtask

  task automatic step(input logic [ND-1:0] ld, adj, inc, rd, input bit rv);
    int c;
    int t;
    @(negedge clk);
    c = cyc;
    t = (force_tap >= 0) ? force_tap : int'($urandom_range(0, 63));
    tap_hist[c % 8192]  = t;
    cntrl_dly_tap_value = TW'(t);
    rst              = rv;
    usr_dly_ld       = rv ? ld  : '0;
    usr_dly_adj      = rv ? adj : '0;
    usr_dly_incdec   = rv ? inc : '0;
    usr_rd_dly_value = rv ? rd  : '0;
    if (!rv) model_reset(c);
    else     model_cycle(c, ld, adj, inc, rd);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, '0, 1'b1);
  endtask

  // Monitor: compares presented vld/ovr/busy/strobes against the model.
  int   acc_kind = 0;
  int   n_str    = 0;
  int   str_cyc  = 0;
  exp_t me;
  ev_t  mo;
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_q.size() > 0 && busy_q[0].cyc == cyc) begin
        chk("busy", longint'(usr_dly_busy), busy_q[0].mask);
        void'(busy_q.pop_front());
      end
      if (usr_dly_ovr != '0) begin
        if (ovr_q.size() > 0 && ovr_q[0].cyc == cyc) begin
          mo = ovr_q.pop_front();
          chk("ovr_mask", longint'(usr_dly_ovr), mo.mask);
        end else chk("ovr_unexpected", longint'(usr_dly_ovr), 0);
      end else if (ovr_q.size() > 0 && ovr_q[0].cyc <= cyc) begin
        mo = ovr_q.pop_front();
        chk("ovr_missing", 0, mo.mask);
      end
      if (cntrl_dly_ld || cntrl_dly_adj || cntrl_dly_incdec) begin
        chk("strobe_excl", longint'((cntrl_dly_ld & cntrl_dly_adj) | (cntrl_dly_incdec & ~cntrl_dly_adj)), 0);
        acc_kind |= {cntrl_dly_ld, cntrl_dly_adj, cntrl_dly_incdec};
        n_str++;
        str_cyc = cyc;
      end
      if (usr_dly_tap_vld != '0) begin
        if (exp_q.size() == 0) chk("vld_unexpected", longint'(usr_dly_tap_vld), 0);
        else begin
          me = exp_q.pop_front();
          chk("vld_cycle", cyc, me.vcyc);
          chk("vld_chan", longint'(usr_dly_tap_vld), 1 << me.ch);
          chk("addr", longint'(f2g_dly_addr), me.addr);
          chk("tap", longint'(usr_dly_tap_value_out[me.ch*TW +: TW]), tap_hist[(cyc - 1) % 8192]);
          chk("strobe_kind", acc_kind, (me.op == 3) ? 4 : (me.op == 2) ? (2 | me.inc) : 0);
          chk("strobe_count", n_str, (me.op == 1) ? 0 : 1);
          if (n_str > 0) chk("strobe_cycle", str_cyc, me.vcyc - RD_LAT - 2);
        end
        acc_kind = 0;
        n_str    = 0;
      end else if (exp_q.size() > 0 && exp_q[0].vcyc < cyc) begin
        me = exp_q.pop_front();
        chk("vld_missing", 0, 1 << me.ch);
      end
      if (!rst) begin
        acc_kind = 0;
        n_str    = 0;
      end
    end
  end

  logic [ND-1:0] rl, ra, ri, rr;
  int            rate;

  initial begin
    for (int k = 0; k < ND; k++) begin
      pend_m[k] = 0;
      inc_m[k]  = 0;
    end
    rst = 1'b0;
    usr_dly_ld = '0; usr_dly_adj = '0; usr_dly_incdec = '0; usr_rd_dly_value = '0;
    cntrl_dly_tap_value = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr",   longint'(f2g_dly_addr), 0);
    chk("rst_strobe", longint'({cntrl_dly_ld, cntrl_dly_adj, cntrl_dly_incdec}), 0);
    chk("rst_tap",    longint'(usr_dly_tap_value_out), 0);
    chk("rst_vld",    longint'(usr_dly_tap_vld), 0);
    chk("rst_busy",   longint'(usr_dly_busy), 0);
    chk("rst_ovr",    longint'(usr_dly_ovr), 0);
    mon_en = 1'b1;

    // adj ch0 (inc) with read ch4 in the same cycle
    step(5'b00000, 5'b00001, 5'b00001, 5'b10000, 1'b1);
    idle(16);
    // every channel loads continuously
    repeat (40) step(5'b11111, '0, '0, '0, 1'b1);
    idle(12);
    // load ch3, GearBox returns 0x2A
    force_tap = 'h2A;
    step(5'b01000, '0, '0, '0, 1'b1);
    idle(10);
    chk("slice3_2a", longint'(usr_dly_tap_value_out[3*TW +: TW]), 'h2A);
    force_tap = -1;
    // second adj on ch2 while first still pending behind ch0
    step(5'b00001, '0, '0, '0, 1'b1);
    idle(1);
    step('0, 5'b00100, '0, '0, 1'b1);
    step('0, 5'b00100, 5'b00100, '0, 1'b1);
    idle(16);
    // same-cycle load and adjust on ch1
    step(5'b00010, 5'b00010, 5'b00010, '0, 1'b1);
    idle(10);
    // reset while ch2 is in WAIT
    step(5'b00100, '0, '0, '0, 1'b1);
    idle(3);
    step('0, '0, '0, '0, 1'b0);
    step('0, '0, '0, '0, 1'b1);
    chk("abort_busy",   longint'(usr_dly_busy), 0);
    chk("abort_addr",   longint'(f2g_dly_addr), 0);
    chk("abort_strobe", longint'({cntrl_dly_ld, cntrl_dly_adj, cntrl_dly_incdec}), 0);
    chk("abort_tap",    longint'(usr_dly_tap_value_out), 0);
    chk("abort_vld",    longint'(usr_dly_tap_vld), 0);
    step(5'b10000, '0, '0, '0, 1'b1);
    idle(10);

    // randomized traffic, light then heavy, with occasional resets
    for (int n = 0; n < 2400; n++) begin
      rate = (n < 1200) ? 3 : 12;
      for (int k = 0; k < ND; k++) begin
        rl[k] = (int'($urandom_range(0, 99)) < rate);
        ra[k] = (int'($urandom_range(0, 99)) < rate);
        ri[k] = $urandom_range(0, 1) != 0;
        rr[k] = (int'($urandom_range(0, 99)) < rate);
      end
      if ($urandom_range(0, 599) == 0) step('0, '0, '0, '0, 1'b0);
      else step(rl, ra, ri, rr, 1'b1);
    end
    idle(40);
    @(negedge clk);
    #1;
    chk("exp_drained",  exp_q.size(), 0);
    chk("ovr_drained",  ovr_q.size(), 0);
    chk("busy_drained", busy_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
